// File: rtl/systolic_skew_feeder_if.sv
// Column-vector stream into the skew feeder: one N-element vector per beat,
// valid/ready handshake, in_last marks the final vector of a stream.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] in_data;
    logic                    in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Left-edge operand feeder for an N-row systolic array. Row i sees each
// column vector i cycles later than row 0, so the wavefront enters the
// array diagonally. pause freezes the PEs whenever no wavefront was issued.
//
// state  | meaning
// IDLE   | waiting for start, chains and edge_out hold
// STREAM | accepting column vectors from upstream
// FLUSH  | shifting zeros until the last vector has reached row N-1
// DONE   | single cycle, done pulses, then back to IDLE
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    systolic_skew_feeder_if.slave   in_bus,
    input  logic                    array_stall,
    output logic [N*DATA_WIDTH-1:0] edge_out,
    output logic                    pause,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    k_count,
    output logic                    busy
);
    // Flush counter must hold N-1; keep at least one bit for N=1.
    localparam int FW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t          state, state_next;
    logic [FW-1:0]   flush_cnt;
    logic            advance;
    logic            clear_chains;

    assign in_bus.in_ready = (state == STREAM) && !array_stall;
    assign busy            = (state == STREAM) || (state == FLUSH);
    assign clear_chains    = (state == IDLE) && start;

    // Advance qualification and next-state selection.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = STREAM;
            end
            STREAM: begin
                advance = in_bus.in_valid && in_bus.in_ready;
                if (advance && in_bus.in_last)
                    state_next = (N > 1) ? FLUSH : DONE;
            end
            FLUSH: begin
                advance = !array_stall;
                if (advance && flush_cnt == FW'(1))
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus the registered pause/done outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pause <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            pause <= !advance;
            done  <= (state_next == DONE);
        end
    end

    // Flush counter: loaded on the last accepted beat, frozen while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flush_cnt <= '0;
        else if (state == STREAM && advance && in_bus.in_last)
            flush_cnt <= FW'(N - 1);
        else if (state == FLUSH && advance)
            flush_cnt <= flush_cnt - FW'(1);
    end

    // Accepted-beat counter, saturating so long streams read as "full".
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            k_count <= '0;
        else if (clear_chains)
            k_count <= '0;
        else if (state == STREAM && advance && k_count != {CNT_WIDTH{1'b1}})
            k_count <= k_count + CNT_WIDTH'(1);
    end

    // Lane i is a chain of i+1 registers; the last stage drives row i.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] chain [0:i];

        // Shift on advance: stage 0 takes the new element (zero in FLUSH).
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) chain[s] <= '0;
            end else if (clear_chains) begin
                for (int s = 0; s <= i; s++) chain[s] <= '0;
            end else if (advance) begin
                chain[0] <= (state == STREAM)
                            ? in_bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]
                            : '0;
                for (int s = 1; s <= i; s++) chain[s] <= chain[s-1];
            end
        end

        assign edge_out[i*DATA_WIDTH +: DATA_WIDTH] = chain[i];
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder (N=4, 16-bit lanes, 2-bit beat
// counter so saturation is reachable). Stimulus pushes expected wavefronts
// and done events; a negedge monitor pops and compares them.
module tb_systolic_skew_feeder;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int CW = 2;

    typedef struct {
        int           cyc;
        logic [CW-1:0] kc;
    } done_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic array_stall = 1'b0;
    logic [N*DW-1:0] edge_out;
    logic pause, done, busy;
    logic [CW-1:0] k_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [N*DW-1:0] exp_vec[$];
    done_exp_t       exp_done[$];
    logic [N*DW-1:0] cur_beats[$];

    systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_bus(bus.slave),
        .array_stall(array_stall),
        .edge_out(edge_out),
        .pause(pause),
        .done(done),
        .k_count(k_count),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [N*DW-1:0] mk(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    // Wavefront seen by the array after advance k: row i carries element i
    // of beat k-i, zero before the first beat and after the last one.
    function automatic logic [N*DW-1:0] wavefront(input int k);
        logic [N*DW-1:0] v;
        logic [N*DW-1:0] b;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (k - i >= 0 && k - i < cur_beats.size()) begin
                b = cur_beats[k-i];
                v[i*DW +: DW] = b[i*DW +: DW];
            end
        end
        return v;
    endfunction

    task automatic push_vectors(input int count);
        for (int k = 0; k < count; k++) exp_vec.push_back(wavefront(k));
    endtask

    task automatic push_done(input int c, input int kc);
        done_exp_t d;
        d.cyc = c;
        d.kc  = CW'(kc);
        exp_done.push_back(d);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [N*DW-1:0] v, input logic last);
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        bus.in_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: done stayed %b, required 1", done);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: every pause-low cycle must present the next expected wavefront.
    always @(negedge clk) begin
        if (!reset) begin
            if (pause === 1'b0) begin
                if (exp_vec.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_wavefront: got %h with pause low, required pause 1", edge_out);
                end else begin
                    check("edge_out", edge_out, exp_vec.pop_front());
                end
            end
            if (done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, required 0", cyc);
                end else begin
                    done_exp_t d;
                    d = exp_done.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.cyc));
                    check("done_k_count", 64'(k_count), 64'(d.kc));
                end
            end
        end
    end

    initial begin
        int t0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // 1: reset values, async assertion, IDLE ignores in_valid
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rst_edge_out", 64'(edge_out), 64'(0));
        check("rst_pause", 64'(pause), 64'(1));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_k_count", 64'(k_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = mk(7, 7, 7, 7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_in_ready", 64'(bus.in_ready), 64'(0));
            check("idle_k_count", 64'(k_count), 64'(0));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        // 2: three beats, no stalls
        cur_beats = '{mk(1, 2, 3, 4), mk(5, 6, 7, 8), mk(9, 10, 11, 12)};
        push_vectors(6);
        do_start();
        t0 = cyc;
        push_done(t0 + 6, 3);
        check("stream_busy", 64'(busy), 64'(1));
        send(cur_beats[0], 1'b0);
        send(cur_beats[1], 1'b0);
        send(cur_beats[2], 1'b1);
        wait_done();
        @(negedge clk);
        check("hold_edge_out", 64'(edge_out), 64'(mk(0, 0, 0, 12)));
        check("hold_pause", 64'(pause), 64'(1));
        check("idle_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;

        // 3: two empty cycles after beat 1
        push_vectors(6);
        do_start();
        t0 = cyc;
        push_done(t0 + 8, 3);
        send(cur_beats[0], 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        send(cur_beats[1], 1'b0);
        send(cur_beats[2], 1'b1);
        wait_done();

        // 4: array_stall for 3 cycles during FLUSH
        push_vectors(6);
        do_start();
        t0 = cyc;
        push_done(t0 + 9, 3);
        send(cur_beats[0], 1'b0);
        send(cur_beats[1], 1'b0);
        send(cur_beats[2], 1'b1);
        @(posedge clk); #1;
        array_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready), 64'(0));
            check("stall_no_done", 64'(done), 64'(0));
            @(posedge clk); #1;
        end
        array_stall = 1'b0;
        wait_done();

        // 5: five beats, beat counter saturates at 3
        cur_beats = '{mk(21, 22, 23, 24), mk(25, 26, 27, 28), mk(29, 30, 31, 32),
                      mk(33, 34, 35, 36), mk(37, 38, 39, 40)};
        push_vectors(8);
        do_start();
        t0 = cyc;
        push_done(t0 + 8, 3);
        for (int b = 0; b < 5; b++) send(cur_beats[b], (b == 4));
        wait_done();

        // 6: reset in FLUSH, then a clean stream
        cur_beats = '{mk(1, 2, 3, 4), mk(5, 6, 7, 8), mk(9, 10, 11, 12)};
        push_vectors(3);
        do_start();
        send(cur_beats[0], 1'b0);
        send(cur_beats[1], 1'b0);
        send(cur_beats[2], 1'b1);
        #6;
        reset = 1'b1;
        #1;
        check("flush_rst_edge_out", 64'(edge_out), 64'(0));
        check("flush_rst_pause", 64'(pause), 64'(1));
        check("flush_rst_busy", 64'(busy), 64'(0));
        check("flush_rst_done", 64'(done), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        push_vectors(6);
        do_start();
        t0 = cyc;
        push_done(t0 + 6, 3);
        send(cur_beats[0], 1'b0);
        send(cur_beats[1], 1'b0);
        send(cur_beats[2], 1'b1);
        wait_done();
        repeat (3) @(posedge clk);

        check("vec_queue_empty", 64'(exp_vec.size()), 64'(0));
        check("done_queue_empty", 64'(exp_done.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
